// File: rtl/alu_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_pkg
// Shared definitions for the ALU operand front end: default operand and
// opcode widths plus the sequencer state encoding. The status-LED decoder
// and the ALU itself read the same encoding, so it lives here rather than
// inside the sequencer.
// ---------------------------------------------------------------------------
package alu_operand_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_OP_W  = 4;

  // The encoding doubles as the number of items collected so far, which is
  // what the board LEDs are meant to show.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    ISSUE = 2'b11
  } seq_state_e;

endpackage : alu_operand_sequencer_pkg

// File: rtl/alu_operand_sequencer_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level signal that is already synchronous to clk.
// The history flop has a parameterised reset value; resetting it to 1 means
// a signal held high across reset release is not reported as an edge.
//
// Ports
//   clk     in  1  clock, rising-edge active
//   rst     in  1  asynchronous, active-high reset
//   sig_in  in  1  level input to watch
//   rise    out 1  high for the cycle in which sig_in is high and was low
// ---------------------------------------------------------------------------
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  // Next history value is simply the current input level.
  always_comb begin
    sig_d = sig_in;
  end

  // History register, cleared to RESET_VAL so a held level is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= RESET_VAL;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule : edge_detect

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Front end of the ALU datapath. Operand A, operand B and the opcode arrive
// one after another on a shared switch bus, one item per rising edge of Load.
// Once all three are held the operation is offered downstream with a
// valid/ready handshake, and the registers stay frozen until it is accepted.
//
// Ports
//   Clk        in  1      system clock, rising-edge active
//   Reset      in  1      asynchronous, active-high reset
//   Data_In    in  WIDTH  shared operand/opcode bus (Clk-synchronous)
//   Load       in  1      capture strobe; each rising edge captures one item
//   Abort      in  1      synchronous cancel of a partial or pending operation
//   Alu_Ready  in  1      downstream ALU accepts the operation
//   Op_A       out WIDTH  registered operand A
//   Op_B       out WIDTH  registered operand B
//   Op_Sel     out OP_W   registered opcode (low OP_W bits of Data_In)
//   Op_Valid   out 1      operation complete; held until accepted
//   State      out 2      current sequencer state for status LEDs
//   Busy       out 1      high whenever State is not IDLE
// ---------------------------------------------------------------------------
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OP_W  = DEFAULT_OP_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Load,
  input  logic             Abort,
  input  logic             Alu_Ready,
  output logic [WIDTH-1:0] Op_A,
  output logic [WIDTH-1:0] Op_B,
  output logic [OP_W-1:0]  Op_Sel,
  output logic             Op_Valid,
  output logic [1:0]       State,
  output logic             Busy
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]  op_sel_q, op_sel_d;
  logic             op_valid_q, op_valid_d;
  logic             load_rise;

  edge_detect #(
    .RESET_VAL (1'b1)
  ) u_load_edge (
    .clk    (Clk),
    .rst    (Reset),
    .sig_in (Load),
    .rise   (load_rise)
  );

  // Next-state and capture logic. Abort outranks everything except reset
  // and swallows any coincident load edge. While an operation is pending,
  // load edges are ignored, including one that lands on the accepting edge,
  // so a new operand is never captured underneath a live handshake.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    op_valid_d = op_valid_q;

    if (Abort) begin
      state_d    = IDLE;
      op_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_rise) begin
            op_a_d  = Data_In;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (load_rise) begin
            op_b_d  = Data_In;
            state_d = GOT_B;
          end
        end
        GOT_B: begin
          if (load_rise) begin
            op_sel_d   = Data_In[OP_W-1:0];
            op_valid_d = 1'b1;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          if (Alu_Ready) begin
            op_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          op_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, operand and valid registers. Operands are cleared only by reset;
  // after a handshake or abort they keep showing the last values captured.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign Op_A     = op_a_q;
  assign Op_B     = op_b_q;
  assign Op_Sel   = op_sel_q;
  assign Op_Valid = op_valid_q;
  assign State    = state_q;
  assign Busy     = (state_q != IDLE);

endmodule : alu_operand_sequencer

// File: tb/tb_alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer
// Self-checking bench for alu_operand_sequencer (WIDTH=8, OP_W=4). A small
// reference model tracks how many items have been collected and what they
// were, and every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       abort;
  logic       alu_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] op_sel;
  logic       op_valid;
  logic [1:0] state;
  logic       busy;

  int check_count;
  int pass_count;
  int fail_count;

  // Reference model: number of items collected (0..3, 3 = offered downstream)
  int       m_items;
  bit       m_prev_load;
  bit [7:0] m_a;
  bit [7:0] m_b;
  bit [3:0] m_sel;

  alu_operand_sequencer #(
    .WIDTH (8),
    .OP_W  (4)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Data_In   (data_in),
    .Load      (load),
    .Abort     (abort),
    .Alu_Ready (alu_ready),
    .Op_A      (op_a),
    .Op_B      (op_b),
    .Op_Sel    (op_sel),
    .Op_Valid  (op_valid),
    .State     (state),
    .Busy      (busy)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Clear the model to its power-on view: nothing captured, and the load
  // history treated as high so a held Load is not an edge.
  task automatic modelReset();
    m_items     = 0;
    m_prev_load = 1'b1;
    m_a         = 8'h00;
    m_b         = 8'h00;
    m_sel       = 4'h0;
  endtask

  // Compare every output against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".op_a"},     32'(op_a),     32'(m_a));
    checkOutput({tag, ".op_b"},     32'(op_b),     32'(m_b));
    checkOutput({tag, ".op_sel"},   32'(op_sel),   32'(m_sel));
    checkOutput({tag, ".op_valid"}, 32'(op_valid), 32'(m_items == 3));
    checkOutput({tag, ".state"},    32'(state),    32'(m_items));
    checkOutput({tag, ".busy"},     32'(busy),     32'(m_items != 0));
  endtask

  // Drive one cycle of inputs, advance the model by the same clock edge
  // and compare the registered results just after the edge.
  task automatic applyStimulus(input string tag, input bit ld, input bit [7:0] d,
                               input bit ab, input bit rdy);
    bit rise;
    load      = ld;
    data_in   = d;
    abort     = ab;
    alu_ready = rdy;
    @(posedge clk);
    rise        = ld && !m_prev_load;
    m_prev_load = ld;
    if (ab) begin
      if (m_items == 3) m_items = 0;
      else              m_items = 0;
    end else if (m_items == 3) begin
      if (rdy) m_items = 0;
    end else if (rise) begin
      if (m_items == 0)      m_a   = d;
      else if (m_items == 1) m_b   = d;
      else                   m_sel = d[3:0];
      m_items = m_items + 1;
    end
    #1;
    checkAll(tag);
  endtask

  // Load a complete operation with separate pulses, Alu_Ready held at rdy.
  task automatic loadOperation(input string tag, input bit [7:0] a, input bit [7:0] b,
                               input bit [7:0] s, input bit rdy);
    applyStimulus(tag, 1'b0, 8'h00, 1'b0, rdy);
    applyStimulus(tag, 1'b1, a,     1'b0, rdy);
    applyStimulus(tag, 1'b0, 8'h00, 1'b0, rdy);
    applyStimulus(tag, 1'b1, b,     1'b0, rdy);
    applyStimulus(tag, 1'b0, 8'h00, 1'b0, rdy);
    applyStimulus(tag, 1'b1, s,     1'b0, rdy);
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    data_in     = 8'h00;
    abort       = 1'b0;
    alu_ready   = 1'b0;
    load        = 1'b1;
    reset       = 1'b1;
    modelReset();

    // Test 1: reset with Load high, release, keep Load high five cycles
    repeat (2) @(posedge clk);
    #1;
    checkAll("t1_in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus("t1_held_load", 1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("t1_no_capture_a", 32'(op_a), 32'h0);

    // Test 2: 3C, 05, 02 with Alu_Ready high, valid for exactly one cycle
    loadOperation("t2_load", 8'h3C, 8'h05, 8'h02, 1'b1);
    checkOutput("t2_valid_up", 32'(op_valid), 32'h1);
    checkOutput("t2_op_a", 32'(op_a), 32'h3C);
    checkOutput("t2_op_b", 32'(op_b), 32'h05);
    checkOutput("t2_op_sel", 32'(op_sel), 32'h2);
    applyStimulus("t2_accept", 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2_valid_down", 32'(op_valid), 32'h0);
    checkOutput("t2_state_idle", 32'(state), 32'h0);

    // Test 3: hold off Alu_Ready while Load keeps pulsing and Data_In toggles
    loadOperation("t3_load", 8'h11, 8'h22, 8'h37, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("t3_stall", i[0] ? 1'b0 : (i < 6), 8'hFF ^ 8'(i * 37), 1'b0, 1'b0);
    checkOutput("t3_state_issue", 32'(state), 32'h3);
    checkOutput("t3_op_a_held", 32'(op_a), 32'h11);
    applyStimulus("t3_accept", 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t3_back_idle", 32'(state), 32'h0);

    // Test 4: abort in GOT_B swallows a coincident load edge
    applyStimulus("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("t4_a",   1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("t4_b",   1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("t4_abort", 1'b1, 8'h09, 1'b1, 1'b0);
    checkOutput("t4_state", 32'(state), 32'h0);
    checkOutput("t4_sel_kept", 32'(op_sel), 32'h7);

    // Test 5: load edge on the accepting edge is discarded
    applyStimulus("t5_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    loadOperation("t5_load", 8'h66, 8'h77, 8'h03, 1'b0);
    applyStimulus("t5_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("t5_accept_load", 1'b1, 8'hAA, 1'b0, 1'b1);
    checkOutput("t5_state", 32'(state), 32'h0);
    checkOutput("t5_op_a_kept", 32'(op_a), 32'h66);

    // Test 6: asynchronous reset mid-cycle while an operation is pending
    loadOperation("t6_load", 8'h81, 8'h92, 8'h0C, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("t6_async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", ($urandom_range(0, 2) != 0) ? 1'(i % 3 != 2) & 1'($urandom) : 1'b0,
                    8'($urandom), ($urandom_range(0, 19) == 0), 1'($urandom));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_alu_operand_sequencer
